// File: rtl/adder_pkg.sv
// Shared widths for the final carry-propagate adder of the Booth-4 / Wallace multiplier.
package adder_pkg;
  localparam int ADD_W = 32;
  localparam int GRP_W = 4;
  localparam int N_GRP = ADD_W / GRP_W;

  typedef logic [ADD_W-1:0] word_t;

  // Group generate/propagate pair produced by each lookahead group
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead group: local carries from cin and bit g/p, plus group G/P for the next level.
module cla_4
  import adder_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             G,
  output logic             P
);
  logic [GRP_W-1:0] g, p, c;

  assign g = a & b;
  assign p = a ^ b;

  // Every in-group carry is flattened to two logic levels from cin
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
endmodule

// File: rtl/adder_32.sv
// Registered 32-bit modulo-2^32 adder built from eight cla_4 groups and a second-level lookahead.
module adder_32
  import adder_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  output logic [ADD_W-1:0] C
);
  logic [N_GRP-1:0][GRP_W-1:0] a_grp, b_grp, s_grp;
  gp_t  [N_GRP-1:0]            gp;
  logic [N_GRP-1:0]            gc;
  word_t                       sum;

  assign a_grp = A;
  assign b_grp = B;

  for (genvar i = 0; i < N_GRP; i++) begin : g_grp
    cla_4 u_cla (
      .a   (a_grp[i]),
      .b   (b_grp[i]),
      .cin (gc[i]),
      .s   (s_grp[i]),
      .G   (gp[i].g),
      .P   (gp[i].p)
    );
  end

  // Group carry-in k is the OR over j<k of G[j] & P[j+1..k-1]; c0 = 0 so its term drops out.
  // Each carry is a flat sum-of-products of group terms, never a ripple through gc.
  always_comb begin
    logic acc;
    logic term;
    gc = '0;
    for (int k = 1; k < N_GRP; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = gp[j].g;
        for (int m = j + 1; m < k; m++) term = term & gp[m].p;
        acc = acc | term;
      end
      gc[k] = acc;
    end
  end

  assign sum = s_grp;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) C <= '0;
    else            C <= sum;
  end
endmodule

// File: tb/tb_adder_32.sv
// Self-checking bench for adder_32: directed corners, async reset, random pipeline vs. scoreboard.
module tb_adder_32;
  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] A, B, C;
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_q[$];

  adder_32 dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .A         (A),
    .B         (B),
    .C         (C)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  // Reference: plain modulo-2^32 addition, queued at drive time
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    return wide[31:0];
  endfunction

  // Drive just after an edge, then check just after the following edge
  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    exp_q.push_back(ref_sum(a, b));
    @(posedge sys_clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b);
    drive(a, b);
    chk(tag, C, exp_q.pop_front());
  endtask

  task automatic step_const(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want);
    drive(a, b);
    void'(exp_q.pop_front());
    chk(tag, C, want);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sys_rst_n = 1'b0;
    A = 32'h0;
    B = 32'h0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_state", C, 32'h0);
    sys_rst_n = 1'b1;

    step_const("zero",        32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    step_const("basic",       32'h0000_1274, 32'h0000_1274, 32'h0000_24E8);
    step_const("wrap",        32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    step_const("msb_carry",   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    step_const("msb_wrap",    32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    step_const("no_carry",    32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
    step_const("grp_cross",   32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000);
    step_const("all_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    step_const("mid_ripple",  32'h0FFF_FFF0, 32'h0000_0010, 32'h1000_0000);
    // Wallace sum/carry pair for 16'h7FFF x 16'h7FFF
    step_const("mult_7fff",   32'h2AAA_5555, 32'h1554_AAAC, 32'h3FFF_0001);

    for (int i = 0; i < 3; i++)
      step_const("rst_pre", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async_clear", C, 32'h0);
    #1;
    sys_rst_n = 1'b1;
    #1;
    chk("rst_hold_til_edge", C, 32'h0);
    @(posedge sys_clk);
    #1;
    chk("rst_restore", C, 32'h2345_6789);

    // Walk a single carry-in through each group boundary
    for (int k = 0; k < 8; k++)
      step("walk_carry", (32'h1 << (4 * k)) - 32'h1, 32'h1);

    for (int i = 0; i < 10000; i++)
      step("random", $urandom, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
